// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution unit.
// Holds the comparator select encodings, jump-kind encodings, RV32I branch funct3 constants,
// the FSM state type and the funct3 decode helpers. The comparator and the decoder both use these.
package branch_resolve_pkg;

   // Comparator select driven on comp_control
   localparam logic [1:0] CompEq = 2'b00;
   localparam logic [1:0] CompNe = 2'b01;
   localparam logic [1:0] CompLt = 2'b10;
   localparam logic [1:0] CompGe = 2'b11;

   // Request kind on br_jump
   localparam logic [1:0] JumpCond = 2'b00;
   localparam logic [1:0] JumpJal  = 2'b01;
   localparam logic [1:0] JumpJalr = 2'b10;
   localparam logic [1:0] JumpRsvd = 2'b11;

   // RV32I conditional branch funct3 values
   localparam logic [2:0] F3Beq = 3'b000;
   localparam logic [2:0] F3Bne = 3'b001;
   localparam logic [2:0] F3Blt = 3'b100;
   localparam logic [2:0] F3Bge = 3'b101;

   typedef enum logic {
      StIdle,
      StFlush
   } state_e;

   // Unused funct3 values map to eq; they are flagged illegal separately.
   function automatic logic [1:0] decode_comp(input logic [2:0] funct3);
      logic [1:0] sel;
      case (funct3)
         F3Beq:   sel = CompEq;
         F3Bne:   sel = CompNe;
         F3Blt:   sel = CompLt;
         F3Bge:   sel = CompGe;
         default: sel = CompEq;
      endcase
      return sel;
   endfunction

   function automatic logic cond_legal(input logic [2:0] funct3);
      return (funct3 == F3Beq) || (funct3 == F3Bne) || (funct3 == F3Blt) || (funct3 == F3Bge);
   endfunction

endpackage

// File: rtl/br_target_calc.sv
// Combinational outcome and target computation for one branch/jump request.
// Ports:
//   br_jump, br_funct3          request kind and branch condition
//   br_pc, br_imm, br_base      instruction PC, sign-extended immediate, JALR base
//   comp_out, pred_taken        comparator result and front-end prediction
//   comp_control                comparator select decoded from br_funct3
//   illegal                     reserved jump kind or unused conditional funct3
//   mispredict                  legal request whose prediction must be corrected
//   target                      next PC (taken target or fall-through), modulo 2^32
module br_target_calc
   import branch_resolve_pkg::*;
#(
   parameter int unsigned RESET_PC_ALIGN = 1
) (
   input  logic [1:0]  br_jump,
   input  logic [2:0]  br_funct3,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_imm,
   input  logic [31:0] br_base,
   input  logic        comp_out,
   input  logic        pred_taken,
   output logic [1:0]  comp_control,
   output logic        illegal,
   output logic        mispredict,
   output logic [31:0] target
);

   logic        taken;
   logic        is_jalr;
   logic [31:0] jalr_target;

   always_comb begin
      comp_control = decode_comp(br_funct3);
      illegal      = 1'b0;
      taken        = 1'b0;
      is_jalr      = 1'b0;
      unique case (br_jump)
         JumpCond: begin
            illegal = !cond_legal(br_funct3);
            taken   = comp_out;
         end
         JumpJal:  taken = 1'b1;
         JumpJalr: begin
            taken   = 1'b1;
            is_jalr = 1'b1;
         end
         JumpRsvd: illegal = 1'b1;
      endcase

      jalr_target = br_base + br_imm;
      if (RESET_PC_ALIGN != 0) begin
         jalr_target[0] = 1'b0;
      end

      if (!taken) begin
         target = br_pc + 32'd4;
      end else if (is_jalr) begin
         target = jalr_target;
      end else begin
         target = br_pc + br_imm;
      end

      // JALR targets are never predicted by the front end, so they always redirect.
      mispredict = !illegal && (is_jalr || (taken != pred_taken));
   end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution unit: accepts one branch/jump per cycle, resolves its outcome against the
// front-end prediction and, on a mispredict, issues a one-cycle redirect followed by a flush
// window of FLUSH_CYCLES cycles during which no request is accepted.
// Ports:
//   clk, rstn                     clock, synchronous active-low reset
//   br_valid / br_ready           request handshake
//   br_jump, br_funct3            request kind and condition
//   br_pc, br_imm, br_base        operands for target computation
//   pred_taken                    front-end prediction
//   comp_control / comp_out       external comparator select and its same-cycle result
//   redirect_valid, redirect_pc   one-cycle redirect pulse and held redirect target
//   flush                         high in every flush cycle
//   br_illegal                    one-cycle pulse after an illegal request is accepted
// Optional (macro BRANCH_RESOLVE_STATS_EN):
//   br_count, mispred_count       saturating counts of legal requests and mispredicts
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES   = 2,
   parameter int unsigned RESET_PC_ALIGN = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        br_valid,
   output logic        br_ready,
   input  logic [1:0]  br_jump,
   input  logic [2:0]  br_funct3,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_imm,
   input  logic [31:0] br_base,
   input  logic        pred_taken,
   output logic [1:0]  comp_control,
   input  logic        comp_out,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush,
`ifdef BRANCH_RESOLVE_STATS_EN
   output logic [31:0] br_count,
   output logic [31:0] mispred_count,
`endif
   output logic        br_illegal
);

   state_e      state_q;
   logic [3:0]  flush_cnt_q;
   logic        redirect_valid_q;
   logic [31:0] redirect_pc_q;
   logic        br_illegal_q;

   logic        accept;
   logic        illegal;
   logic        mispredict;
   logic [31:0] target;

   br_target_calc #(
      .RESET_PC_ALIGN (RESET_PC_ALIGN)
   ) u_target_calc (
      .br_jump      (br_jump),
      .br_funct3    (br_funct3),
      .br_pc        (br_pc),
      .br_imm       (br_imm),
      .br_base      (br_base),
      .comp_out     (comp_out),
      .pred_taken   (pred_taken),
      .comp_control (comp_control),
      .illegal      (illegal),
      .mispredict   (mispredict),
      .target       (target)
   );

   assign br_ready = (state_q == StIdle);
   assign flush    = (state_q == StFlush);
   assign accept   = br_valid && br_ready;

   // flush_cnt_q holds the remaining flush cycles after the current one.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q          <= StIdle;
         flush_cnt_q      <= 4'd0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= 32'd0;
         br_illegal_q     <= 1'b0;
      end else begin
         redirect_valid_q <= 1'b0;
         br_illegal_q     <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  if (illegal) begin
                     br_illegal_q <= 1'b1;
                  end else if (mispredict) begin
                     redirect_valid_q <= 1'b1;
                     redirect_pc_q    <= target;
                     flush_cnt_q      <= 4'(FLUSH_CYCLES - 1);
                     state_q          <= StFlush;
                  end
               end
            end
            StFlush: begin
               if (flush_cnt_q == 4'd0) begin
                  state_q <= StIdle;
               end else begin
                  flush_cnt_q <= flush_cnt_q - 4'd1;
               end
            end
         endcase
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign br_illegal     = br_illegal_q;

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] br_count_q;
   logic [31:0] mispred_count_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         br_count_q      <= 32'd0;
         mispred_count_q <= 32'd0;
      end else if (accept && !illegal) begin
         if (br_count_q != 32'hFFFF_FFFF) begin
            br_count_q <= br_count_q + 32'd1;
         end
         if (mispredict && (mispred_count_q != 32'hFFFF_FFFF)) begin
            mispred_count_q <= mispred_count_q + 32'd1;
         end
      end
   end

   assign br_count      = br_count_q;
   assign mispred_count = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

   localparam int unsigned FlushCycles = 2;

   logic        clk = 1'b0;
   logic        rstn;
   logic        br_valid;
   logic        br_ready;
   logic [1:0]  br_jump;
   logic [2:0]  br_funct3;
   logic [31:0] br_pc;
   logic [31:0] br_imm;
   logic [31:0] br_base;
   logic        pred_taken;
   logic [1:0]  comp_control;
   logic        comp_out;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        br_illegal;
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] br_count;
   logic [31:0] mispred_count;
`endif

   always #5 clk = ~clk;

   branch_resolve #(
      .FLUSH_CYCLES   (FlushCycles),
      .RESET_PC_ALIGN (1)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .br_valid       (br_valid),
      .br_ready       (br_ready),
      .br_jump        (br_jump),
      .br_funct3      (br_funct3),
      .br_pc          (br_pc),
      .br_imm         (br_imm),
      .br_base        (br_base),
      .pred_taken     (pred_taken),
      .comp_control   (comp_control),
      .comp_out       (comp_out),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
`ifdef BRANCH_RESOLVE_STATS_EN
      .br_count       (br_count),
      .mispred_count  (mispred_count),
`endif
      .br_illegal     (br_illegal)
   );

   typedef struct {
      bit          is_illegal;
      logic [31:0] pc;
   } ev_t;

   ev_t         exp_q[$];
   int          m_flush = 0;        // flush cycles still to come, 0 means ready
   logic [31:0] m_pc = 32'd0;       // last redirect target
   int unsigned m_br = 0;
   int unsigned m_mis = 0;
   bit          started = 1'b0;
   int          checks = 0;
   int          errors = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [1:0] exp_cc(input logic [2:0] f3);
      case (f3)
         3'd0:    return 2'd0;
         3'd1:    return 2'd1;
         3'd4:    return 2'd2;
         3'd5:    return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // Reference: outcome, target and mispredict straight from the branch rules.
   function automatic void ref_resolve(input logic [1:0] jump, input logic [2:0] f3,
                                       input logic [31:0] pc, input logic [31:0] imm,
                                       input logic [31:0] base, input bit comp, input bit pred,
                                       output bit ill, output bit mis, output logic [31:0] tgt);
      bit taken;
      ill   = (jump == 2'd3) || ((jump == 2'd0) && !(f3 inside {3'd0, 3'd1, 3'd4, 3'd5}));
      taken = (jump == 2'd0) ? comp : 1'b1;
      if (!taken)           tgt = pc + 32'd4;
      else if (jump == 2'd2) tgt = (base + imm) & 32'hFFFF_FFFE;
      else                  tgt = pc + imm;
      mis = !ill && ((jump == 2'd2) || (taken != pred));
   endfunction

   task automatic issue(input bit rst_v, input bit valid, input logic [1:0] jump,
                        input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] base, input bit comp, input bit pred);
      bit          acc;
      bit          ill;
      bit          mis;
      logic [31:0] tgt;
      rstn       = rst_v;
      br_valid   = valid;
      br_jump    = jump;
      br_funct3  = f3;
      br_pc      = pc;
      br_imm     = imm;
      br_base    = base;
      comp_out   = comp;
      pred_taken = pred;
      acc = rst_v && valid && (m_flush == 0);
      ref_resolve(jump, f3, pc, imm, base, comp, pred, ill, mis, tgt);
      @(posedge clk);
      if (!rst_v) begin
         m_flush = 0;
         m_pc    = 32'd0;
         m_br    = 0;
         m_mis   = 0;
         exp_q.delete();
      end else if (acc) begin
         if (ill) begin
            exp_q.push_back('{is_illegal: 1'b1, pc: 32'd0});
         end else begin
            if (m_br != 32'hFFFF_FFFF) m_br++;
            if (mis) begin
               if (m_mis != 32'hFFFF_FFFF) m_mis++;
               m_pc    = tgt;
               m_flush = FlushCycles;
               exp_q.push_back('{is_illegal: 1'b0, pc: tgt});
            end
         end
      end else if (m_flush > 0) begin
         m_flush--;
      end
      started = 1'b1;
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(1'b1, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   // Monitor: per-cycle state checks and scoreboard pops for redirect/illegal events.
   always @(negedge clk) begin
      if (started) begin
         ev_t ev;
         chk("br_ready", {31'd0, br_ready}, {31'd0, m_flush == 0});
         chk("flush", {31'd0, flush}, {31'd0, m_flush != 0});
         chk("redirect_pc", redirect_pc, m_pc);
         chk("comp_control", {30'd0, comp_control}, {30'd0, exp_cc(br_funct3)});
         if (redirect_valid || br_illegal) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: got redirect=%0b illegal=%0b expected none",
                        redirect_valid, br_illegal);
            end else begin
               ev = exp_q.pop_front();
               chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, !ev.is_illegal});
               chk("br_illegal", {31'd0, br_illegal}, {31'd0, ev.is_illegal});
            end
         end else if (exp_q.size() != 0) begin
            ev = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got none expected illegal=%0b pc=%h",
                     ev.is_illegal, ev.pc);
         end
`ifdef BRANCH_RESOLVE_STATS_EN
         chk("br_count", br_count, m_br);
         chk("mispred_count", mispred_count, m_mis);
`endif
      end
   end

   initial begin
      issue(1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      issue(1'b0, 1'b1, 2'd1, 3'd0, 32'h40, 32'h8, 32'd0, 1'b0, 1'b0);
      idle(1);

      // BEQ taken, predicted not taken: redirect to 0x120, two flush cycles
      issue(1'b1, 1'b1, 2'd0, 3'b000, 32'h100, 32'h20, 32'd0, 1'b1, 1'b0);
      idle(3);

      // Four back-to-back correctly predicted BNEs
      for (int i = 0; i < 4; i++)
         issue(1'b1, 1'b1, 2'd0, 3'b001, 32'h200 + 32'(i * 4), 32'h40, 32'd0, i[0], i[0]);
      idle(1);

      // JALR with odd base, redirects even when predicted taken
      issue(1'b1, 1'b1, 2'd2, 3'd0, 32'h500, 32'h4, 32'h1001, 1'b0, 1'b1);
      idle(3);

      // JAL wrapping past 2^32
      issue(1'b1, 1'b1, 2'd1, 3'd0, 32'hFFFF_FFF0, 32'h20, 32'd0, 1'b0, 1'b0);
      idle(3);

      // Illegal funct3, then a mispredict interrupted by reset in its first flush cycle
      issue(1'b1, 1'b1, 2'd0, 3'b110, 32'h600, 32'h10, 32'd0, 1'b1, 1'b1);
      issue(1'b1, 1'b1, 2'd0, 3'b100, 32'h700, 32'h30, 32'd0, 1'b1, 1'b0);
      issue(1'b0, 1'b1, 2'd1, 3'd0, 32'h800, 32'h30, 32'd0, 1'b0, 1'b0);
      idle(2);

      // Three legal requests, one mispredict
      issue(1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      issue(1'b1, 1'b1, 2'd0, 3'b000, 32'h900, 32'h8, 32'd0, 1'b0, 1'b0);
      issue(1'b1, 1'b1, 2'd0, 3'b101, 32'h904, 32'h8, 32'd0, 1'b1, 1'b1);
      issue(1'b1, 1'b1, 2'd1, 3'd0, 32'h908, 32'h100, 32'd0, 1'b0, 1'b0);
      idle(3);
`ifdef BRANCH_RESOLVE_STATS_EN
      @(negedge clk);
      chk("br_count_three", br_count, 32'd3);
      chk("mispred_count_one", mispred_count, 32'd1);
`endif

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         bit          rv;
         bit          v;
         int          k;
         logic [1:0]  j;
         logic [2:0]  f3;
         logic [31:0] imm;
         rv = ($urandom_range(0, 49) != 0);
         v  = ($urandom_range(0, 4) != 0);
         k  = $urandom_range(0, 9);
         j  = (k < 6) ? 2'd0 : (k < 8) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
         f3 = ($urandom_range(0, 4) != 0) ? 3'($urandom_range(0, 1) + 4 * $urandom_range(0, 1))
                                          : 3'($urandom_range(0, 7));
         imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed(12'($urandom)));
         issue(rv, v, j, f3, $urandom & 32'hFFFF_FFFC, imm, $urandom, 1'($urandom),
               1'($urandom));
      end
      idle(4);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
